// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared types, field moduli and BCD helper for the time-unit counter
package time_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int SEC_MOD  = 60;
  localparam int MIN_MOD  = 60;
  localparam int HOUR_MOD = 24;

  // Two-digit BCD of a binary value below 100.
  function automatic logic [7:0] bin_to_bcd8(input logic [6:0] bin);
    int v;
    int tens;
    v    = int'(bin);
    tens = v / 10;
    return {4'(tens), 4'(v - tens * 10)};
  endfunction

endpackage

// File: rtl/tuc_prescaler.sv
// rtl/tuc_prescaler.sv - tick prescaler; step_en marks the tick that advances the value
module tuc_prescaler #(
  parameter  int PRESCALE = 60,
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic clr,
  input  logic hold,
  output logic step_en
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] r_pre_cnt;
  logic             w_at_last;

  assign w_at_last = (r_pre_cnt == PRE_LAST);
  // clr and hold outrank tick, so a discarded tick never produces a step.
  assign step_en   = tick & ~hold & ~clr & w_at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pre_cnt <= '0;
    end else if (clr) begin
      r_pre_cnt <= '0;
    end else if (!hold && tick) begin
      if (w_at_last) begin
        r_pre_cnt <= '0;
      end else begin
        r_pre_cnt <= r_pre_cnt + PRE_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_unit_counter.sv
// rtl/time_unit_counter.sv - cascadable modulo-MOD time field with prescaler, up/down, clamped load
// Optional TUC_BCD_OUT_EN adds a registered two-digit BCD copy of the value.
module time_unit_counter
  import time_pkg::*;
#(
  parameter  int MOD       = SEC_MOD,
  parameter  int PRESCALE  = 60,
  parameter  int RESET_VAL = 0,
  localparam int VAL_W     = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             set,
  input  logic [VAL_W-1:0] set_value,
  input  logic             dir,
  input  logic             hold,
  output logic [VAL_W-1:0] value,
  output logic             carry,
  output logic             set_clamp
`ifdef TUC_BCD_OUT_EN
  ,
  output logic [7:0]       bcd_value
`endif
);

  localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(MOD - 1);

  logic [VAL_W-1:0] r_value;
  logic             r_carry;
  logic             r_set_clamp;
  logic             w_step_en;
  logic [VAL_W-1:0] w_value_nxt;
  logic             w_carry_nxt;
  logic             w_clamp_nxt;

  tuc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .clr     (set),
    .hold    (hold),
    .step_en (w_step_en)
  );

  // Wraps use explicit compares against MAX_VAL so non-power-of-2 moduli work.
  always_comb begin
    w_value_nxt = r_value;
    w_carry_nxt = 1'b0;
    w_clamp_nxt = 1'b0;
    if (set) begin
      if (set_value > MAX_VAL) begin
        w_value_nxt = MAX_VAL;
        w_clamp_nxt = 1'b1;
      end else begin
        w_value_nxt = set_value;
      end
    end else if (w_step_en) begin
      if (dir_e'(dir) == DIR_DOWN) begin
        if (r_value == '0) begin
          w_value_nxt = MAX_VAL;
          w_carry_nxt = 1'b1;
        end else begin
          w_value_nxt = r_value - VAL_W'(1);
        end
      end else begin
        if (r_value == MAX_VAL) begin
          w_value_nxt = '0;
          w_carry_nxt = 1'b1;
        end else begin
          w_value_nxt = r_value + VAL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_value     <= VAL_W'(RESET_VAL);
      r_carry     <= 1'b0;
      r_set_clamp <= 1'b0;
    end else begin
      r_value     <= w_value_nxt;
      r_carry     <= w_carry_nxt;
      r_set_clamp <= w_clamp_nxt;
    end
  end

  assign value     = r_value;
  assign carry     = r_carry;
  assign set_clamp = r_set_clamp;

`ifdef TUC_BCD_OUT_EN
  if (MOD > 100) begin : g_bcd_range
    $error("time_unit_counter: TUC_BCD_OUT_EN requires MOD <= 100");
  end

  logic [7:0] r_bcd_value;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcd_value <= bin_to_bcd8(7'(RESET_VAL));
    end else begin
      r_bcd_value <= bin_to_bcd8(7'(w_value_nxt));
    end
  end

  assign bcd_value = r_bcd_value;
`endif

endmodule

// File: tb/tb_time_unit_counter.sv
// tb/tb_time_unit_counter.sv - directed self-checking bench for time_unit_counter
module tb_time_unit_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       tick_a, set_a, dir_a, hold_a;
  logic [5:0] sv_a;
  logic [5:0] val_a;
  logic       carry_a, clamp_a;

  logic       tick_b, set_b, dir_b, hold_b;
  logic [4:0] sv_b;
  logic [4:0] val_b;
  logic       carry_b, clamp_b;

  logic       tick_c, set_c, dir_c, hold_c;
  logic [5:0] sv_c;
  logic [5:0] val_c;
  logic       carry_c, clamp_c;

`ifdef TUC_BCD_OUT_EN
  logic [7:0] bcd_a, bcd_b, bcd_c;
`endif

  int checks   = 0;
  int failures = 0;
  int n_carry;

  time_unit_counter #(.MOD(60), .PRESCALE(1), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .tick(tick_a), .set(set_a), .set_value(sv_a), .dir(dir_a),
    .hold(hold_a), .value(val_a), .carry(carry_a), .set_clamp(clamp_a)
`ifdef TUC_BCD_OUT_EN
    , .bcd_value(bcd_a)
`endif
  );

  time_unit_counter #(.MOD(24), .PRESCALE(3), .RESET_VAL(0)) dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .set(set_b), .set_value(sv_b), .dir(dir_b),
    .hold(hold_b), .value(val_b), .carry(carry_b), .set_clamp(clamp_b)
`ifdef TUC_BCD_OUT_EN
    , .bcd_value(bcd_b)
`endif
  );

  time_unit_counter #(.MOD(60), .PRESCALE(60), .RESET_VAL(5)) dut_c (
    .clk(clk), .reset(reset), .tick(tick_c), .set(set_c), .set_value(sv_c), .dir(dir_c),
    .hold(hold_c), .value(val_c), .carry(carry_c), .set_clamp(clamp_c)
`ifdef TUC_BCD_OUT_EN
    , .bcd_value(bcd_c)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {tick_a, set_a, dir_a, hold_a, sv_a} = '0;
    {tick_b, set_b, dir_b, hold_b, sv_b} = '0;
    {tick_c, set_c, dir_c, hold_c, sv_c} = '0;
    cyc();
    cyc();
    chk("rst_val_a", val_a, 0);
    chk("rst_carry_a", carry_a, 0);
    chk("rst_clamp_a", clamp_a, 0);
    chk("rst_val_b", val_b, 0);
    chk("rst_pre_b", dut_b.u_prescaler.r_pre_cnt, 0);
    chk("rst_val_c", val_c, 5);
`ifdef TUC_BCD_OUT_EN
    chk("rst_bcd_c", bcd_c, 8'h05);
`endif
    reset = 1'b0;
    cyc();

    // dut_a: one full revolution, modulus 60 with no prescale
    tick_a  = 1'b1;
    n_carry = 0;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (carry_a) n_carry++;
      chk("up_val_a", val_a, k % 60);
      chk("up_carry_a", carry_a, (k == 60) ? 1 : 0);
    end
    tick_a = 1'b0;
    chk("up_ncarry_a", n_carry, 1);
    cyc();
    chk("up_carry_drop_a", carry_a, 0);

    // down count through zero
    dir_a  = 1'b1;
    tick_a = 1'b1;
    cyc();
    chk("dn_wrap_val_a", val_a, 59);
    chk("dn_wrap_carry_a", carry_a, 1);
    cyc();
    chk("dn_next_val_a", val_a, 58);
    chk("dn_next_carry_a", carry_a, 0);
    tick_a = 1'b0;
    dir_a  = 1'b0;

    // clamped loads and set-over-tick priority
    set_a = 1'b1;
    sv_a  = 6'd62;
    cyc();
    chk("clamp62_val", val_a, 59);
    chk("clamp62_flag", clamp_a, 1);
    sv_a = 6'd60;
    cyc();
    chk("clamp60_val", val_a, 59);
    chk("clamp60_flag", clamp_a, 1);
    sv_a = 6'd59;
    cyc();
    chk("load59_val", val_a, 59);
    chk("load59_flag", clamp_a, 0);
    sv_a   = 6'd23;
    tick_a = 1'b1;
    cyc();
    chk("set_tick_val_a", val_a, 23);
    chk("set_tick_carry_a", carry_a, 0);
    chk("set_tick_clamp_a", clamp_a, 0);
    set_a  = 1'b0;
    tick_a = 1'b0;
    cyc();
    chk("hold_after_set_a", val_a, 23);

`ifdef TUC_BCD_OUT_EN
    set_a = 1'b1;
    sv_a  = 6'd47;
    cyc();
    chk("bcd47", bcd_a, 8'h47);
    sv_a = 6'd58;
    cyc();
    set_a  = 1'b0;
    tick_a = 1'b1;
    cyc();
    chk("bcd59", bcd_a, 8'h59);
    cyc();
    chk("bcd_wrap", bcd_a, 8'h00);
    tick_a = 1'b0;
`endif

    // dut_b: modulus 24 with a prescale of 3
    tick_b = 1'b1;
    repeat (5) cyc();
    tick_b = 1'b0;
    chk("p3_5_val_b", val_b, 1);
    chk("p3_5_pre_b", dut_b.u_prescaler.r_pre_cnt, 2);
    tick_b = 1'b1;
    cyc();
    tick_b = 1'b0;
    chk("p3_6_val_b", val_b, 2);
    chk("p3_6_pre_b", dut_b.u_prescaler.r_pre_cnt, 0);

    tick_b = 1'b1;
    cyc();
    set_b = 1'b1;
    sv_b  = 5'd7;
    cyc();
    set_b = 1'b0;
    chk("set_tick_val_b", val_b, 7);
    chk("set_tick_pre_b", dut_b.u_prescaler.r_pre_cnt, 0);
    chk("set_tick_carry_b", carry_b, 0);

    cyc();
    hold_b = 1'b1;
    repeat (10) cyc();
    chk("hold_val_b", val_b, 7);
    chk("hold_pre_b", dut_b.u_prescaler.r_pre_cnt, 1);
    chk("hold_carry_b", carry_b, 0);
    hold_b = 1'b0;
    cyc();
    dir_b = 1'b1;
    #1;
    chk("dir_keeps_pre_b", dut_b.u_prescaler.r_pre_cnt, 2);
    cyc();
    chk("dir_step_val_b", val_b, 6);
    chk("dir_step_pre_b", dut_b.u_prescaler.r_pre_cnt, 0);
    dir_b  = 1'b0;
    tick_b = 1'b0;

    set_b = 1'b1;
    sv_b  = 5'd0;
    cyc();
    set_b   = 1'b0;
    tick_b  = 1'b1;
    n_carry = 0;
    repeat (72) begin
      cyc();
      if (carry_b) n_carry++;
    end
    tick_b = 1'b0;
    chk("p3_72_ncarry_b", n_carry, 1);
    chk("p3_72_val_b", val_b, 0);
    chk("p3_72_pre_b", dut_b.u_prescaler.r_pre_cnt, 0);

    dir_b  = 1'b1;
    tick_b = 1'b1;
    cyc();
    cyc();
    chk("dn2_val_b", val_b, 0);
    cyc();
    chk("dn3_val_b", val_b, 23);
    chk("dn3_carry_b", carry_b, 1);
    dir_b  = 1'b0;
    tick_b = 1'b0;

    // asynchronous reset mid-prescale, with dut_a carrying at the same moment
    set_c = 1'b1;
    sv_c  = 6'd59;
    set_a = 1'b1;
    sv_a  = 6'd59;
    cyc();
    set_c  = 1'b0;
    set_a  = 1'b0;
    tick_c = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 40) tick_a = 1'b1;
      cyc();
    end
    tick_c = 1'b0;
    tick_a = 1'b0;
    chk("pre40_pre_c", dut_c.u_prescaler.r_pre_cnt, 40);
    chk("pre40_val_c", val_c, 59);
    chk("pre40_carry_a", carry_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_val_c", val_c, 5);
    chk("async_pre_c", dut_c.u_prescaler.r_pre_cnt, 0);
    chk("async_carry_a", carry_a, 0);
    chk("async_val_b", val_b, 0);
    cyc();
    #2 reset = 1'b0;
    cyc();
    tick_c = 1'b1;
    repeat (59) cyc();
    chk("restart59_val_c", val_c, 5);
    chk("restart59_pre_c", dut_c.u_prescaler.r_pre_cnt, 59);
    cyc();
    tick_c = 1'b0;
    chk("restart60_val_c", val_c, 6);
    chk("restart60_pre_c", dut_c.u_prescaler.r_pre_cnt, 0);
    chk("restart60_carry_c", carry_c, 0);
    chk("restart_clamp_c", clamp_c, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
